// File: rtl/rv32i_encoder_pkg.sv
// Shared definitions for the RV32I streaming encoder.
//   - op_type_e   : field-bundle instruction format selector (OP_*_TYPE)
//   - OPC_*       : RV32I major opcode constants (the encoder copies opcode
//                   verbatim; these are for producers and benches)
//   - NOP         : canonical addi x0,x0,0, emitted for unknown op types
//   - enc_entry_t : one buffered output word {last, err, addr, instr}
package rv32i_encoder_pkg;

  typedef enum logic [3:0] {
    OP_R_TYPE     = 4'd0,
    OP_I_TYPE     = 4'd1,
    OP_S_TYPE     = 4'd2,
    OP_B_TYPE     = 4'd3,
    OP_U_TYPE     = 4'd4,
    OP_J_TYPE     = 4'd5,
    OP_ECALL_TYPE = 4'd6
  } op_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        last;
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } enc_entry_t;

endpackage

// File: rtl/rv32i_encoder_fifo.sv
// Synchronous FIFO for encoded words.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   i_push, i_data  : write request / entry; ignored when full
//   i_pop           : read request; ignored when empty
//   o_data          : head entry (valid only when !o_empty)
//   o_full, o_empty : status, from pointer MSB comparison
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without an occupancy counter. No pass-through: a push while full is
// dropped even if a pop happens in the same cycle.
module rv32i_enc_fifo
  import rv32i_encoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  enc_entry_t i_data,
  input  logic       i_pop,
  output enc_entry_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  enc_entry_t  r_mem [DEPTH];
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I instruction encoder.
// Packs a decoded field bundle into a 32-bit instruction word tagged with a
// byte address, and buffers the result in a FIFO for the program loader.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; a bundle transfers on a rising
//                         edge where both are high. Producer must hold the
//                         bundle stable while in_valid && !in_ready.
//   in_op..in_imm       : fields (op type, opcode, funct3/7, rs1/rs2/rd, imm)
//   in_last             : bundle is the last of a program
//   out_valid/out_ready : output handshake; a word leaves on a rising edge
//                         where both are high
//   out_instr/out_addr  : encoded word and its byte address
//   out_err             : field error for this word
//   done                : one-cycle pulse after the last word of a program pops
//   err_count           : (RV32I_ENC_IMM_CHECK_EN only) saturating count of
//                         errored words pushed
// Configuration macro: RV32I_ENC_IMM_CHECK_EN enables immediate range checks
// and the err_count port. Without it, out_err flags only unknown op types.
module rv32i_encoder
  import rv32i_encoder_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        done
`ifdef RV32I_ENC_IMM_CHECK_EN
  ,
  output logic [7:0]  err_count
`endif
);

  logic        w_accept;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_instr;
  logic        w_op_err;
  logic        w_err;
  enc_entry_t  w_push_data;
  enc_entry_t  w_head;

  logic [31:0] r_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_addr;
  logic        r_hold_err;
  logic        r_done;

  assign in_ready  = !rst && !w_full;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  // Encode mux: opcode is always copied verbatim; unknown op types become NOP.
  always_comb begin
    w_instr  = NOP;
    w_op_err = 1'b0;
    case (in_op)
      OP_R_TYPE:
        w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      OP_I_TYPE, OP_ECALL_TYPE:
        w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_S_TYPE:
        w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_B_TYPE:
        w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
      OP_U_TYPE:
        w_instr = {in_imm[31:12], in_rd, in_opcode};
      OP_J_TYPE:
        w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default:
        w_op_err = 1'b1;
    endcase
  end

`ifdef RV32I_ENC_IMM_CHECK_EN
  logic       w_rng_err;
  logic [7:0] r_err_count;

  // A value fits an N-bit signed field when every bit above the field's sign
  // bit equals that sign bit.
  always_comb begin
    w_rng_err = 1'b0;
    case (in_op)
      OP_I_TYPE, OP_S_TYPE, OP_ECALL_TYPE:
        w_rng_err = (in_imm[31:11] != {21{in_imm[11]}});
      OP_B_TYPE:
        w_rng_err = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
      OP_J_TYPE:
        w_rng_err = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
      OP_U_TYPE:
        w_rng_err = (in_imm[11:0] != 12'h000);
      default:
        w_rng_err = 1'b0;
    endcase
  end

  assign w_err = w_op_err || w_rng_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if (w_accept && w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign w_err = w_op_err;
`endif

  // Address counter: current value tags the accepted word; the last word of
  // a program rewinds to BASE_ADDR for the next program.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= BASE_ADDR;
    end else if (w_accept) begin
      r_addr <= in_last ? BASE_ADDR : (r_addr + 32'd4);
    end
  end

  assign w_push_data = {in_last, w_err, r_addr, w_instr};

  rv32i_enc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Keep a copy of the last popped word so outputs hold while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_instr <= 32'h0;
      r_hold_addr  <= 32'h0;
      r_hold_err   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_pop && w_head.last;
      if (w_pop) begin
        r_hold_instr <= w_head.instr;
        r_hold_addr  <= w_head.addr;
        r_hold_err   <= w_head.err;
      end
    end
  end

  assign out_instr = w_empty ? r_hold_instr : w_head.instr;
  assign out_addr  = w_empty ? r_hold_addr  : w_head.addr;
  assign out_err   = w_empty ? r_hold_err   : w_head.err;
  assign done      = r_done;

endmodule

// File: tb/tb_rv32i_encoder.sv
module tb_rv32i_encoder;
  import rv32i_encoder_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        done;
`ifdef RV32I_ENC_IMM_CHECK_EN
  logic [7:0]  err_count;
`endif

  rv32i_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .done      (done)
`ifdef RV32I_ENC_IMM_CHECK_EN
    ,
    .err_count (err_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // {last, err, addr[31:0], instr[31:0]}
  logic [65:0] exp_q[$];
  logic [31:0] exp_addr = BASE;
  int          exp_err_cnt = 0;
  logic        done_pend = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Field placement computed with shifts/masks from the format tables.
  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [6:0] opc,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [4:0] rd, input logic [31:0] imm);
    int unsigned u, lo12, base_r, w;
    u      = imm;
    lo12   = u & 32'hFFF;
    base_r = (int'(rs1) << 15) | (int'(f3) << 12) | int'(opc);
    case (op)
      4'd0: w = (int'(f7) << 25) | (int'(rs2) << 20) | base_r | (int'(rd) << 7);
      4'd1, 4'd6: w = (lo12 << 20) | base_r | (int'(rd) << 7);
      4'd2: w = ((lo12 >> 5) << 25) | (int'(rs2) << 20) | base_r | ((lo12 & 31) << 7);
      4'd3: w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (int'(rs2) << 20) | base_r
                | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7);
      4'd4: w = (u & 32'hFFFF_F000) | (int'(rd) << 7) | int'(opc);
      4'd5: w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 255) << 12) | (int'(rd) << 7) | int'(opc);
      default: w = 32'h0000_0013;
    endcase
    return w;
  endfunction

  function automatic logic ref_err(input logic [3:0] op, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    if (op > 4'd6) return 1'b1;
`ifdef RV32I_ENC_IMM_CHECK_EN
    case (op)
      4'd1, 4'd2, 4'd6: return (s < -2048) || (s > 2047);
      4'd3: return (s < -4096) || (s > 4094) || imm[0];
      4'd5: return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 2) || imm[0];
      4'd4: return (imm % 4096) != 0;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  // use_k selects a hand-computed instr/err instead of the model.
  task automatic send(input logic [3:0] op, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [31:0] imm, input logic last,
                      input logic use_k, input logic [31:0] k_instr, input logic k_err);
    logic rdy;
    logic [31:0] e_instr;
    logic e_err;
    bit accepted;
    accepted = 0;
    in_op = op; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        accepted = 1;
        break;
      end
    end
    if (accepted) begin
      e_instr = use_k ? k_instr : ref_encode(op, opc, f3, f7, rs1, rs2, rd, imm);
      e_err   = use_k ? k_err : ref_err(op, imm);
      exp_q.push_back({last, e_err, exp_addr, e_instr});
      exp_addr = last ? BASE : exp_addr + 32'd4;
      if (e_err && exp_err_cnt < 255) exp_err_cnt++;
    end else begin
      check_eq("send_timeout", 1, 0);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [3:0] op;
    logic [31:0] imm;
    int r;
    int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4097,
                    -1048576, 1048574, 1048575, -1048578, 32'h1234_5000, 32'h0000_0800};
    r = $urandom_range(0, 15);
    if (r < 7) op = 4'(r);
    else if (r < 14) op = 4'($urandom_range(0, 6));
    else op = 4'($urandom_range(7, 15));
    case ($urandom_range(0, 3))
      0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: imm = bnd[$urandom_range(0, 13)];
      2: imm = $urandom;
      default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
    endcase
    send(op, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
         5'($urandom), imm, $urandom_range(0, 7) == 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check_eq("drain_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    exp_addr = BASE;
    exp_err_cnt = 0;
    @(negedge clk);
    check_eq("rst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_out_instr", out_instr, 0);
    check_eq("rst_out_addr", out_addr, 0);
    check_eq("rst_out_err", out_err, 0);
`ifdef RV32I_ENC_IMM_CHECK_EN
    check_eq("rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [65:0] e;
    if (rst) begin
      done_pend = 1'b0;
    end else begin
      check_eq("done", done, done_pend);
      done_pend = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_valid", out_valid, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check_eq("instr", out_instr, e[31:0]);
          check_eq("addr", out_addr, e[63:32]);
          check_eq("err", out_err, e[64]);
          done_pend = e[65];
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  bit rand_done;

  initial begin
    do_reset();

    // 1. add x3,x1,x2
    send(4'd0, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b1, 32'h002081B3, 1'b0);
    wait_drain();
    check_eq("hold_valid", out_valid, 0);
    check_eq("hold_instr", out_instr, 32'h002081B3);
    check_eq("hold_addr", out_addr, BASE);

    // 2. addi / sw / lui back to back
    send(4'd1, OPC_OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 1'b0, 1'b1, 32'h00500093, 1'b0);
    send(4'd2, OPC_STORE, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 1'b0, 1'b1, 32'h0020A423, 1'b0);
    send(4'd4, OPC_LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b0, 1'b1, 32'h123452B7, 1'b0);

    // 3. beq x0,x0,-4 and jal x1,8
    send(4'd3, OPC_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b0, 1'b1, 32'hFE000EE3, 1'b0);
    send(4'd5, OPC_JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 1'b0, 1'b1, 32'h008000EF, 1'b0);
    wait_drain();

    // 4. backpressure: fill, hold the next bundle, pop one, then it enters
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_rand_nolast();
    fork
      send(4'd0, OPC_OP, 3'd7, 7'h20, 5'd9, 5'd10, 5'd11, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      begin
        @(negedge clk);
        check_eq("full_in_ready", in_ready, 0);
        @(negedge clk);
        check_eq("held_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check_eq("ready_after_pop", in_ready, 1);
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // 5. program of 3 words, then next word restarts at BASE
    send(4'd1, OPC_OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd2, 32'd1, 1'b0, 1'b0, 32'h0, 1'b0);
    send(4'd1, OPC_OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd3, 32'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    send(4'd1, OPC_OP_IMM, 3'd0, 7'd0, 5'd4, 5'd0, 5'd4, 32'd3, 1'b1, 1'b0, 32'h0, 1'b0);
    wait_drain();
    send(4'd0, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_drain();
    check_eq("restart_addr", out_addr, BASE);

    // 6. error cases and mid-stream reset
    do_reset();
`ifdef RV32I_ENC_IMM_CHECK_EN
    send(4'd1, OPC_OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b0, 1'b1, 32'h80000093, 1'b1);
    wait_drain();
    check_eq("err_count_1", err_count, 1);
`else
    send(4'd1, OPC_OP_IMM, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048, 1'b0, 1'b1, 32'h80000093, 1'b0);
    wait_drain();
`endif
    send(4'hF, OPC_OP, 3'd1, 7'd1, 5'd1, 5'd1, 5'd1, 32'h7, 1'b0, 1'b1, 32'h00000013, 1'b1);
    wait_drain();
    out_ready = 1'b0;
    send(4'd0, OPC_OP, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    send(4'd0, OPC_OP, 3'd0, 7'd0, 5'd4, 5'd5, 5'd6, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    check_eq("queued_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    do_reset();
    send(4'd4, OPC_AUIPC, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'hABCDE000, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_drain();
    check_eq("post_rst_addr", out_addr, BASE);

    // 7. randomized traffic with random output backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) send_rand();
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
`ifdef RV32I_ENC_IMM_CHECK_EN
    check_eq("err_count_rand", err_count, 64'(exp_err_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic send_rand_nolast();
    send(4'($urandom_range(0, 6)), 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom),
         5'($urandom), 5'($urandom), 32'($urandom_range(0, 2047)) & ~32'd1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Global watchdog.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
